alu_seq: RTL and testbench

Parametrised, multi-cycle successor to the 16-bit combinational ALU.
It keeps the same 4-bit opcode map and adds working add, sub, mul, div and mod, a persistent carry flag (clr_c/set_c), a registered 4-bit CCR, and a start/done handshake.
Logic ops complete in 1 cycle; mul/div/mod use an iterative WIDTH-step datapath.
It sits between the register file and the writeback/branch logic of the CPU datapath.

---
 rtl/alu_pkg.sv | 33 +++
 rtl/alu_seq_if.sv | 23 ++
 rtl/alu_muldiv_iter.sv | 53 +++++
 rtl/alu_seq.sv | 153 +++++++++++++++
 tb/tb_alu_seq.sv | 166 ++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared opcode map, CCR bit positions and FSM encoding for the sequential ALU.
package alu_pkg;

  localparam logic [3:0] OP_NOP_A = 4'h0;
  localparam logic [3:0] OP_NOP_B = 4'h1;
  localparam logic [3:0] OP_NOT_A = 4'h2;
  localparam logic [3:0] OP_AND   = 4'h3;
  localparam logic [3:0] OP_OR    = 4'h4;
  localparam logic [3:0] OP_XOR   = 4'h5;
  localparam logic [3:0] OP_ADD   = 4'h6;
  localparam logic [3:0] OP_SUB   = 4'h7;
  localparam logic [3:0] OP_MUL   = 4'h8;
  localparam logic [3:0] OP_DIV   = 4'h9;
  localparam logic [3:0] OP_MOD   = 4'hA;
  localparam logic [3:0] OP_CLR_C = 4'hB;
  localparam logic [3:0] OP_SET_C = 4'hC;

  localparam int unsigned CCR_N = 3;
  localparam int unsigned CCR_Z = 2;
  localparam int unsigned CCR_V = 1;
  localparam int unsigned CCR_C = 0;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ITER   = 2'd1,
    ST_FINISH = 2'd2
  } state_t;

  function automatic logic is_iter_op(input logic [3:0] op);
    return (op == OP_MUL) || (op == OP_DIV) || (op == OP_MOD);
  endfunction

endpackage

// File: rtl/alu_seq_if.sv
// Operation request / result bundle between the register file side and the ALU.
interface alu_seq_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic [3:0]       operation;
  logic [WIDTH-1:0] reg_a;
  logic [WIDTH-1:0] reg_b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] c_out;
  logic [3:0]       ccr;

  modport master (
    output start, operation, reg_a, reg_b,
    input  busy, done, c_out, ccr
  );

  modport slave (
    input  start, operation, reg_a, reg_b,
    output busy, done, c_out, ccr
  );
endinterface

// File: rtl/alu_muldiv_iter.sv
// One-bit-per-cycle unsigned shift-add multiplier and restoring divider.
// {hi,lo} holds the product, or remainder/quotient, after WIDTH steps.
module alu_muldiv_iter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             step,
  input  logic             is_mul,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  logic [WIDTH-1:0] acc, q, m;
  logic             mode_mul;
  logic [WIDTH:0]   sum, part, diff;

  always_comb begin
    sum  = {1'b0, acc} + (q[0] ? {1'b0, m} : '0);
    part = {acc, q[WIDTH-1]};
    diff = part - {1'b0, m};
  end

  // acc is the shared accumulator: product high half for mul, partial remainder for div
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc      <= '0;
      q        <= '0;
      m        <= '0;
      mode_mul <= 1'b0;
    end else if (load) begin
      acc      <= '0;
      q        <= op_a;
      m        <= op_b;
      mode_mul <= is_mul;
    end else if (step) begin
      if (mode_mul) begin
        {acc, q} <= {sum, q[WIDTH-1:1]};
      end else if (!diff[WIDTH]) begin
        acc <= diff[WIDTH-1:0];
        q   <= {q[WIDTH-2:0], 1'b1};
      end else begin
        acc <= part[WIDTH-1:0];
        q   <= {q[WIDTH-2:0], 1'b0};
      end
    end
  end

  assign hi = acc;
  assign lo = q;
endmodule

// File: rtl/alu_seq.sv
// Multi-cycle ALU: single-cycle logic/add/sub, WIDTH-step mul/div/mod,
// persistent carry and registered {N,Z,V,C} flags behind a start/done handshake.
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input logic       clk,
  input logic       rst,
  alu_seq_if.slave  bus
);
  localparam int unsigned CNT_W = $clog2(WIDTH) + 1;
  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [3:0]       op_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic             busy_r, done_r;
  logic [WIDTH-1:0] c_out_r;
  logic [3:0]       ccr_r;

  logic             accept, load_iter;
  logic [WIDTH-1:0] a_mag, b_mag, hi, lo;

  assign accept    = (state == ST_IDLE) && bus.start;
  assign load_iter = accept && is_iter_op(bus.operation);
  assign a_mag     = bus.reg_a[WIDTH-1] ? -bus.reg_a : bus.reg_a;
  assign b_mag     = bus.reg_b[WIDTH-1] ? -bus.reg_b : bus.reg_b;

  alu_muldiv_iter #(.WIDTH(WIDTH)) u_iter (
    .clk    (clk),
    .rst    (rst),
    .load   (load_iter),
    .step   (state == ST_ITER),
    .is_mul (bus.operation == OP_MUL),
    .op_a   (a_mag),
    .op_b   (b_mag),
    .hi     (hi),
    .lo     (lo)
  );

  logic             a_neg, b_neg, sgn_neg, mul_v, v, c;
  logic [2*WIDTH-1:0] prod, lim;
  logic [WIDTH-1:0] sgn_lo, rem, res;

  // Iteration ran on magnitudes; the low half of -prod depends only on lo,
  // so one negation serves both the product and the quotient.
  always_comb begin
    a_neg   = a_q[WIDTH-1];
    b_neg   = b_q[WIDTH-1];
    sgn_neg = a_neg ^ b_neg;
    prod    = {hi, lo};
    lim     = '0;
    lim[WIDTH-1] = 1'b1;
    mul_v   = sgn_neg ? (prod > lim) : (prod >= lim);
    sgn_lo  = sgn_neg ? -lo : lo;
    rem     = a_neg ? -hi : hi;
    res     = '0;
    v       = 1'b0;
    c       = ccr_r[CCR_C];
    case (op_q)
      OP_NOP_A: res = a_q;
      OP_NOP_B: res = b_q;
      OP_NOT_A: res = ~a_q;
      OP_AND:   res = a_q & b_q;
      OP_OR:    res = a_q | b_q;
      OP_XOR:   res = a_q ^ b_q;
      OP_ADD: begin
        {c, res} = {1'b0, a_q} + {1'b0, b_q};
        v = (a_neg == b_neg) && (res[WIDTH-1] != a_neg);
      end
      OP_SUB: begin
        res = a_q - b_q;
        c   = a_q < b_q;
        v   = (a_neg != b_neg) && (res[WIDTH-1] != a_neg);
      end
      OP_MUL: begin
        res = sgn_lo;
        v   = mul_v;
      end
      OP_DIV: begin
        if (b_q == '0) begin
          res = '1;
          v   = 1'b1;
        end else begin
          res = sgn_lo;
          v   = (a_q == MIN_VAL) && (b_q == '1);
        end
      end
      OP_MOD: begin
        if (b_q == '0) begin
          res = a_q;
          v   = 1'b1;
        end else begin
          res = rem;
        end
      end
      OP_CLR_C: c = 1'b0;
      OP_SET_C: c = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      c_out_r <= '0;
      ccr_r   <= '0;
    end else begin
      done_r <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            op_q   <= bus.operation;
            a_q    <= bus.reg_a;
            b_q    <= bus.reg_b;
            busy_r <= 1'b1;
            if (is_iter_op(bus.operation)) begin
              cnt   <= CNT_W'(WIDTH);
              state <= ST_ITER;
            end else begin
              state <= ST_FINISH;
            end
          end
        end
        ST_ITER: begin
          cnt <= cnt - 1'b1;
          if (cnt == CNT_W'(1)) state <= ST_FINISH;
        end
        ST_FINISH: begin
          c_out_r <= res;
          ccr_r   <= {res[WIDTH-1], res == '0, v, c};
          done_r  <= 1'b1;
          busy_r  <= 1'b0;
          state   <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.busy  = busy_r;
  assign bus.done  = done_r;
  assign bus.c_out = c_out_r;
  assign bus.ccr   = ccr_r;
endmodule

// File: tb/tb_alu_seq.sv
// Directed-vector bench for alu_seq: results, flags, latency, reset abort and handshake.
module tb_alu_seq;
  import alu_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  alu_seq_if #(.WIDTH(16)) bus ();

  alu_seq #(.WIDTH(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one op in the current cycle, wait for done, check result, flags and latency.
  task automatic do_op(input string tag, input logic [3:0] op, input logic [15:0] a,
                       input logic [15:0] b, input logic [15:0] exp_res,
                       input logic [3:0] exp_ccr, input int exp_lat);
    int n;
    bus.start     = 1'b1;
    bus.operation = op;
    bus.reg_a     = a;
    bus.reg_b     = b;
    tick();
    bus.start = 1'b0;
    n = 1;
    check_val({tag, "_busy"}, 32'(bus.busy), 32'd1);
    while (bus.done !== 1'b1 && n < 60) begin
      tick();
      n++;
    end
    check_val({tag, "_done"}, 32'(bus.done), 32'd1);
    check_val({tag, "_lat"}, 32'(n), 32'(exp_lat));
    check_val({tag, "_res"}, 32'(bus.c_out), 32'(exp_res));
    check_val({tag, "_ccr"}, 32'(bus.ccr), 32'(exp_ccr));
  endtask

  initial begin
    int          exp_done_at;
    int          next_free;
    int          dones;
    logic [15:0] exp_val;
    logic        seen_done;

    rst           = 1'b1;
    bus.start     = 1'b0;
    bus.operation = '0;
    bus.reg_a     = '0;
    bus.reg_b     = '0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    check_val("rst_busy", 32'(bus.busy), 32'd0);
    check_val("rst_done", 32'(bus.done), 32'd0);
    check_val("rst_cout", 32'(bus.c_out), 32'd0);
    check_val("rst_ccr",  32'(bus.ccr), 32'd0);

    // Reset mid-divide after leaving a non-zero result behind
    do_op("nop_a", OP_NOP_A, 16'h1234, 16'h0000, 16'h1234, 4'b0000, 2);
    bus.start = 1'b1; bus.operation = OP_DIV; bus.reg_a = 16'd100; bus.reg_b = 16'd7;
    tick();
    bus.start = 1'b0;
    repeat (4) tick();
    rst = 1'b1;
    #1;
    check_val("abort_busy", 32'(bus.busy), 32'd0);
    check_val("abort_cout", 32'(bus.c_out), 32'd0);
    check_val("abort_ccr",  32'(bus.ccr), 32'd0);
    tick();
    rst = 1'b0;
    seen_done = 1'b0;
    for (int i = 0; i < 25; i++) begin
      if (bus.done === 1'b1) seen_done = 1'b1;
      tick();
    end
    check_val("abort_no_done", 32'(seen_done), 32'd0);

    do_op("add_v",   OP_ADD, 16'h7FFF, 16'h0001, 16'h8000, 4'b1010, 2);
    do_op("add_c",   OP_ADD, 16'hFFFF, 16'h0001, 16'h0000, 4'b0101, 2);
    do_op("sub_bor", OP_SUB, 16'h0003, 16'h0005, 16'hFFFE, 4'b1001, 2);
    do_op("sub_v",   OP_SUB, 16'h8000, 16'h0001, 16'h7FFF, 4'b0010, 2);
    do_op("div_neg", OP_DIV, 16'hFFF9, 16'h0002, 16'hFFFD, 4'b1000, 18);
    do_op("mod_neg", OP_MOD, 16'hFFF9, 16'h0002, 16'hFFFF, 4'b1000, 18);
    do_op("div_nb",  OP_DIV, 16'h0007, 16'hFFFE, 16'hFFFD, 4'b1000, 18);
    do_op("mod_nb",  OP_MOD, 16'h0007, 16'hFFFE, 16'h0001, 4'b0000, 18);
    do_op("div_100", OP_DIV, 16'd100,  16'd7,    16'd14,   4'b0000, 18);
    do_op("div_z",   OP_DIV, 16'h0005, 16'h0000, 16'hFFFF, 4'b1010, 18);
    do_op("mod_z",   OP_MOD, 16'h0005, 16'h0000, 16'h0005, 4'b0010, 18);
    do_op("div_min", OP_DIV, 16'h8000, 16'hFFFF, 16'h8000, 4'b1010, 18);
    do_op("set_c",   OP_SET_C, 16'h1111, 16'h2222, 16'h0000, 4'b0101, 2);
    do_op("mul_ov",  OP_MUL, 16'd300,  16'd300,  16'h5F90, 4'b0011, 18);
    do_op("mul_neg", OP_MUL, 16'd100,  16'hFF9C, 16'hD8F0, 4'b1001, 18);
    do_op("op_e",    4'hE,   16'h0005, 16'h0003, 16'h0000, 4'b0101, 2);
    do_op("clr_c",   OP_CLR_C, 16'h0000, 16'h0000, 16'h0000, 4'b0100, 2);
    do_op("and",     OP_AND, 16'hF0F0, 16'h3C3C, 16'h3030, 4'b0000, 2);
    do_op("or",      OP_OR,  16'hF0F0, 16'h3C3C, 16'hFCFC, 4'b1000, 2);
    do_op("xor",     OP_XOR, 16'hF0F0, 16'h3C3C, 16'hCCCC, 4'b1000, 2);
    do_op("not_a",   OP_NOT_A, 16'hFFFF, 16'h1234, 16'h0000, 4'b0100, 2);
    do_op("nop_b",   OP_NOP_B, 16'h0000, 16'h8001, 16'h8001, 4'b1000, 2);

    // start held high: one accept per 2 cycles, and starts during the divide are ignored
    tick();
    next_free   = 0;
    exp_done_at = -1;
    exp_val     = '0;
    dones       = 0;
    for (int i = 0; i < 42; i++) begin
      if (i <= 39) begin
        bus.start = 1'b1;
        if (i == 10) begin
          bus.operation = OP_DIV; bus.reg_a = 16'd100; bus.reg_b = 16'd7;
        end else begin
          bus.operation = (i % 2 == 1) ? OP_NOP_B : OP_NOP_A;
          bus.reg_a = 16'h0200 + 16'(i);
          bus.reg_b = 16'h0300 + 16'(i);
        end
      end else begin
        bus.start = 1'b0;
      end
      check_val($sformatf("hs_done_%0d", i), 32'(bus.done), 32'(i == exp_done_at));
      if (i == exp_done_at) begin
        dones++;
        check_val($sformatf("hs_cout_%0d", i), 32'(bus.c_out), 32'(exp_val));
      end
      if (i <= 39 && i >= next_free) begin
        if (i == 10) begin
          exp_val = 16'd14;
          exp_done_at = i + 18;
        end else begin
          exp_val = (i % 2 == 1) ? 16'h0300 + 16'(i) : 16'h0200 + 16'(i);
          exp_done_at = i + 2;
        end
        next_free = exp_done_at;
      end
      tick();
    end
    check_val("hs_count", 32'(dones), 32'd12);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end
endmodule
